// File: rtl/drive_dma_ctrl.sv
// -----------------------------------------------------------------------------
// drive_dma_ctrl
//   Bus initiator that copies blocks of words between the drive extension
//   (24-bit word address, shared 16-bit tristate data bus) and main memory
//   (16-bit word address). The CPU programs the direction, both start
//   addresses and a word count, then pulses start. Each word takes one FETCH
//   cycle, in which the source is read into a holding register, and one STORE
//   cycle, in which the destination is written. A single DONE cycle ends the
//   command.
//
//   Optional build macro DRIVE_DMA_CHECKSUM_EN adds a running modulo-2^DW sum
//   of the transferred words on checksum. Without it, checksum is tied to 0.
//
// Ports
//   clk             system clock
//   r               synchronous active-low reset
//   start           command strobe, honoured only in IDLE
//   dir             0 = drive -> memory, 1 = memory -> drive
//   cmd_drive_addr  first drive word address
//   cmd_mem_addr    first memory word address
//   cmd_count       number of words to move (0 = no bus activity)
//   busy            high in every non-IDLE state
//   done            one-cycle completion pulse
//   checksum        running word sum (0 unless DRIVE_DMA_CHECKSUM_EN)
//   drive_bus       shared drive data bus, driven only while drive_we
//   drive_addr      drive word address
//   drive_we        drive write strobe (drive captures at posedge)
//   drive_oe        drive output enable (drive returns data combinationally)
//   mem_addr        memory word address
//   mem_wdata       memory write data
//   mem_rdata       memory read data, valid while mem_oe
//   mem_we          memory write strobe
//   mem_oe          memory output enable
// -----------------------------------------------------------------------------
module drive_dma_ctrl #(
  parameter int DRIVE_AW = 24,
  parameter int MEM_AW   = 16,
  parameter int DW       = 16,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                r,
  input  logic                start,
  input  logic                dir,
  input  logic [DRIVE_AW-1:0] cmd_drive_addr,
  input  logic [MEM_AW-1:0]   cmd_mem_addr,
  input  logic [CNT_W-1:0]    cmd_count,
  output logic                busy,
  output logic                done,
  output logic [DW-1:0]       checksum,
  inout  wire  [DW-1:0]       drive_bus,
  output logic [DRIVE_AW-1:0] drive_addr,
  output logic                drive_we,
  output logic                drive_oe,
  output logic [MEM_AW-1:0]   mem_addr,
  output logic [DW-1:0]       mem_wdata,
  input  logic [DW-1:0]       mem_rdata,
  output logic                mem_we,
  output logic                mem_oe
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    STORE,
    DONE
  } state_t;

  state_t              state, state_nxt;
  logic                dir_q;
  logic [DRIVE_AW-1:0] drive_addr_q;
  logic [MEM_AW-1:0]   mem_addr_q;
  logic [CNT_W-1:0]    remain_q;
  logic [DW-1:0]       hold_q;
  logic                accept;

  assign accept = (state == IDLE) && start;

  // Sequential state: command registers, address/count stepping and the
  // holding register that carries one word from FETCH to STORE.
  always_ff @(posedge clk) begin
    if (!r) begin
      // NOTE: the holding register is reset as well because it is visible on
      // mem_wdata; a pure datapath register with no observable output would
      // not need it.
      state        <= IDLE;
      dir_q        <= 1'b0;
      drive_addr_q <= '0;
      mem_addr_q   <= '0;
      remain_q     <= '0;
      hold_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values of the others, matching real flip-flop behaviour.
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (start) begin
            dir_q        <= dir;
            drive_addr_q <= cmd_drive_addr;
            mem_addr_q   <= cmd_mem_addr;
            remain_q     <= cmd_count;
          end
        end
        FETCH: hold_q <= dir_q ? mem_rdata : drive_bus;
        STORE: begin
          // Natural wrap of the fixed-width adders gives modulo addressing.
          drive_addr_q <= drive_addr_q + DRIVE_AW'(1);
          mem_addr_q   <= mem_addr_q + MEM_AW'(1);
          remain_q     <= remain_q - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Next state and bus strobes.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // through the case statement can infer a latch.
    state_nxt = state;
    drive_oe  = 1'b0;
    drive_we  = 1'b0;
    mem_oe    = 1'b0;
    mem_we    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = (cmd_count == '0) ? DONE : FETCH;
      end
      FETCH: begin
        drive_oe  = !dir_q;
        mem_oe    = dir_q;
        state_nxt = STORE;
      end
      STORE: begin
        drive_we  = dir_q;
        mem_we    = !dir_q;
        state_nxt = (remain_q == CNT_W'(1)) ? DONE : FETCH;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign drive_addr = drive_addr_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = hold_q;

  // The controller owns the drive bus only while it is writing the drive.
  assign drive_bus  = drive_we ? hold_q : {DW{1'bz}};

`ifdef DRIVE_DMA_CHECKSUM_EN
  logic [DW-1:0] sum_q;

  // Cleared on an accepted command, accumulates the word being stored, and
  // otherwise holds, so the DONE value stays visible until the next start.
  always_ff @(posedge clk) begin
    if (!r) begin
      sum_q <= '0;
    end else if (accept) begin
      sum_q <= '0;
    end else if (state == STORE) begin
      sum_q <= sum_q + hold_q;
    end
  end

  assign checksum = sum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_drive_dma_ctrl.sv
// -----------------------------------------------------------------------------
// tb_drive_dma_ctrl
//   Directed bench for drive_dma_ctrl. Models a small drive (addressed by the
//   low 8 address bits, full addresses logged) and a full 64K-word memory,
//   logs every write with its address, and runs a background bus-ownership
//   checker alongside the directed steps.
// -----------------------------------------------------------------------------
module tb_drive_dma_ctrl;

  localparam int DRIVE_AW = 24;
  localparam int MEM_AW   = 16;
  localparam int DW       = 16;
  localparam int CNT_W    = 16;

  logic                clk = 1'b0;
  logic                r;
  logic                start;
  logic                dir;
  logic [DRIVE_AW-1:0] cmd_drive_addr;
  logic [MEM_AW-1:0]   cmd_mem_addr;
  logic [CNT_W-1:0]    cmd_count;
  logic                busy;
  logic                done;
  logic [DW-1:0]       checksum;
  wire  [DW-1:0]       drive_bus;
  logic [DRIVE_AW-1:0] drive_addr;
  logic                drive_we;
  logic                drive_oe;
  logic [MEM_AW-1:0]   mem_addr;
  logic [DW-1:0]       mem_wdata;
  logic [DW-1:0]       mem_rdata;
  logic                mem_we;
  logic                mem_oe;

  drive_dma_ctrl #(
    .DRIVE_AW(DRIVE_AW), .MEM_AW(MEM_AW), .DW(DW), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .r(r), .start(start), .dir(dir),
    .cmd_drive_addr(cmd_drive_addr), .cmd_mem_addr(cmd_mem_addr),
    .cmd_count(cmd_count), .busy(busy), .done(done), .checksum(checksum),
    .drive_bus(drive_bus), .drive_addr(drive_addr), .drive_we(drive_we),
    .drive_oe(drive_oe), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_we(mem_we), .mem_oe(mem_oe)
  );

  always #5 clk = ~clk;

  // ---------------- memory and drive models ----------------
  logic [DW-1:0] mem  [0:65535];
  logic [DW-1:0] dmem [0:255];
  logic          poke_m, poke_d;
  logic [23:0]   poke_addr;
  logic [DW-1:0] poke_data;

  assign mem_rdata = mem_oe ? mem[mem_addr] : 16'hDEAD;
  assign drive_bus = drive_oe ? dmem[drive_addr[7:0]] : {DW{1'bz}};

  logic [39:0] dwlog [$];   // {drive_addr, data} per drive write
  logic [31:0] mwlog [$];   // {mem_addr, data} per memory write
  logic [15:0] mrlog [$];   // mem_addr per memory read
  int          cyc_cnt  = 0;
  int          done_cnt = 0;
  int          strb_cnt = 0;

  always @(posedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (poke_m) mem[poke_addr[15:0]] <= poke_data;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
    if (poke_d) dmem[poke_addr[7:0]] <= poke_data;
    else if (drive_we) dmem[drive_addr[7:0]] <= drive_bus;
    if (mem_we)   mwlog.push_back({mem_addr, mem_wdata});
    if (drive_we) dwlog.push_back({drive_addr, drive_bus});
    if (mem_oe)   mrlog.push_back(mem_addr);
  end

  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (drive_we || drive_oe || mem_we || mem_oe) strb_cnt <= strb_cnt + 1;
  end

  // ---------------- checking ----------------
  int checks   = 0;
  int failures = 0;
  int t0       = 0;

  task automatic check(input string tag, input logic [39:0] obs,
                       input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input bit to_mem, input logic [23:0] a,
                      input logic [DW-1:0] d);
    @(negedge clk);
    poke_m    = to_mem;
    poke_d    = !to_mem;
    poke_addr = a;
    poke_data = d;
    @(negedge clk);
    poke_m = 1'b0;
    poke_d = 1'b0;
  endtask

  // Presents a command for one cycle; returns at the negedge of cycle 1,
  // i.e. the first cycle after the accepting edge.
  task automatic issue(input logic d, input logic [23:0] da,
                       input logic [15:0] ma, input logic [15:0] cnt);
    @(negedge clk);
    start          = 1'b1;
    dir            = d;
    cmd_drive_addr = da;
    cmd_mem_addr   = ma;
    cmd_count      = cnt;
    @(negedge clk);
    start = 1'b0;
    t0    = cyc_cnt;
  endtask

  // Cycle index (1 = first cycle after the start edge) in which done is seen.
  task automatic wait_done(input string tag, output int cyc);
    int budget = 200;
    while (!done && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    cyc = cyc_cnt - t0 + 1;
    if (budget == 0) check({tag, "_timeout"}, 40'd0, 40'd1);
  endtask

  logic [DW-1:0] exp_sum;
  int            cyc, base_d, base_m, base_r, base_done, base_strb;

  initial begin
    r = 1'b0; start = 1'b0; dir = 1'b0; poke_m = 1'b0; poke_d = 1'b0;
    poke_addr = '0; poke_data = '0;
    cmd_drive_addr = '0; cmd_mem_addr = '0; cmd_count = '0;

    // Bus ownership checker running for the whole simulation.
    fork
      forever begin
        @(negedge clk);
        if (drive_we || drive_oe) check("bus_we_oe_excl", {39'd0, drive_we & drive_oe}, 40'd0);
        if (mem_we || mem_oe)     check("mem_we_oe_excl", {39'd0, mem_we & mem_oe}, 40'd0);
        if (drive_oe) check("bus_no_contention", {24'd0, drive_bus}, {24'd0, dmem[drive_addr[7:0]]});
      end
    join_none

    // ---- reset state ----
    repeat (2) @(negedge clk);
    check("rst_busy",   {39'd0, busy}, 40'd0);
    check("rst_done",   {39'd0, done}, 40'd0);
    check("rst_strobes", {36'd0, drive_we, drive_oe, mem_we, mem_oe}, 40'd0);
    check("rst_addrs",  {drive_addr, mem_addr}, 40'd0);
    check("rst_wdata_sum", {8'd0, mem_wdata, checksum}, 40'd0);
    r = 1'b1;

    // ---- preload models ----
    poke(1'b0, 24'h000010, 16'h1111);
    poke(1'b0, 24'h000011, 16'h2222);
    poke(1'b0, 24'h000012, 16'h3333);
    poke(1'b0, 24'h000013, 16'h4444);
    poke(1'b1, 24'h00FFFE, 16'hBEEF);
    poke(1'b1, 24'h00FFFF, 16'hCAFE);
    poke(1'b1, 24'h000000, 16'h1234);
    poke(1'b1, 24'h000005, 16'h5A5A);

    // ---- test 1: drive -> memory, 4 words ----
    base_m = mwlog.size();
    issue(1'b0, 24'h000010, 16'h0200, 16'd4);
    check("t1_busy", {39'd0, busy}, 40'd1);
    wait_done("t1", cyc);
    check("t1_done_cycle", 40'(cyc), 40'd9);
`ifdef DRIVE_DMA_CHECKSUM_EN
    exp_sum = 16'hAAAA;
`else
    exp_sum = 16'h0000;
`endif
    check("t1_checksum", {24'd0, checksum}, {24'd0, exp_sum});
    @(negedge clk);
    check("t1_mem_writes", 40'(mwlog.size() - base_m), 40'd4);
    check("t1_mem200", {24'd0, mem[16'h0200]}, 40'h1111);
    check("t1_mem201", {24'd0, mem[16'h0201]}, 40'h2222);
    check("t1_mem202", {24'd0, mem[16'h0202]}, 40'h3333);
    check("t1_mem203", {24'd0, mem[16'h0203]}, 40'h4444);
    check("t1_final_addrs", {drive_addr, mem_addr}, {24'h000014, 16'h0204});
    check("t1_idle", {39'd0, busy}, 40'd0);
    check("t1_sum_hold", {24'd0, checksum}, {24'd0, exp_sum});

    // ---- test 2: memory -> drive, 3 words with wrap ----
    base_d = dwlog.size();
    base_r = mrlog.size();
    issue(1'b1, 24'hFFFFFF, 16'hFFFE, 16'd3);
    wait_done("t2", cyc);
    check("t2_done_cycle", 40'(cyc), 40'd7);
`ifdef DRIVE_DMA_CHECKSUM_EN
    exp_sum = 16'h9C21;   // BEEF + CAFE + 1234 mod 2^16
`else
    exp_sum = 16'h0000;
`endif
    check("t2_checksum", {24'd0, checksum}, {24'd0, exp_sum});
    @(negedge clk);
    check("t2_drive_writes", 40'(dwlog.size() - base_d), 40'd3);
    check("t2_mem_wrap_addr", {24'd0, mrlog[base_r + 2]}, 40'h0000);
    check("t2_wr0", dwlog[base_d + 0], {24'hFFFFFF, 16'hBEEF});
    check("t2_wr1", dwlog[base_d + 1], {24'h000000, 16'hCAFE});
    check("t2_wr2", dwlog[base_d + 2], {24'h000001, 16'h1234});
    check("t2_final_addrs", {drive_addr, mem_addr}, {24'h000002, 16'h0001});

    // ---- test 3: count 0 ----
    base_strb = strb_cnt;
    base_done = done_cnt;
    issue(1'b0, 24'h000040, 16'h0040, 16'd0);
    check("t3_done_next", {38'd0, done, busy}, 40'd3);
    @(negedge clk);
    check("t3_idle_after", {38'd0, done, busy}, 40'd0);
    check("t3_no_strobes", 40'(strb_cnt - base_strb), 40'd0);
    check("t3_one_done", 40'(done_cnt - base_done), 40'd1);

    // ---- test 4: start while busy is ignored ----
    base_m    = mwlog.size();
    base_d    = dwlog.size();
    base_done = done_cnt;
    issue(1'b0, 24'h000010, 16'h0400, 16'd4);
    repeat (2) @(negedge clk);
    start = 1'b1; dir = 1'b1; cmd_count = 16'd7;
    cmd_drive_addr = 24'h000080; cmd_mem_addr = 16'h0800;
    @(negedge clk);
    start = 1'b0;
    wait_done("t4", cyc);
    check("t4_done_cycle", 40'(cyc), 40'd9);
    repeat (4) @(negedge clk);
    check("t4_mem_writes", 40'(mwlog.size() - base_m), 40'd4);
    check("t4_drive_writes", 40'(dwlog.size() - base_d), 40'd0);
    check("t4_one_done", 40'(done_cnt - base_done), 40'd1);
    check("t4_last_write", {8'd0, mwlog[base_m + 3]}, {8'd0, 16'h0403, 16'h4444});
    check("t4_idle", {39'd0, busy}, 40'd0);

    // ---- test 5: reset during STORE of word 2 of 5 ----
    base_done = done_cnt;
    issue(1'b0, 24'h000010, 16'h0300, 16'd5);
    repeat (3) @(negedge clk);            // cycle 4: STORE of word 2
    check("t5_in_store", {39'd0, mem_we}, 40'd1);
    r = 1'b0;
    @(negedge clk);
    check("t5_strobes", {36'd0, drive_we, drive_oe, mem_we, mem_oe}, 40'd0);
    check("t5_busy", {39'd0, busy}, 40'd0);
    check("t5_addrs", {drive_addr, mem_addr}, 40'd0);
    r = 1'b1;
    repeat (3) @(negedge clk);
    check("t5_no_done", 40'(done_cnt - base_done), 40'd0);
    check("t5_still_idle", {39'd0, busy}, 40'd0);

    base_d = dwlog.size();
    issue(1'b1, 24'h000020, 16'h0005, 16'd1);
    wait_done("t5b", cyc);
    check("t5b_done_cycle", 40'(cyc), 40'd3);
    @(negedge clk);
    check("t5b_writes", 40'(dwlog.size() - base_d), 40'd1);
    check("t5b_word", dwlog[base_d], {24'h000020, 16'h5A5A});

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/drive_dma_ctrl.md
Name: drive_dma_ctrl

Overview:
- Bus initiator that copies word blocks between the 16-bit/24-bit-address drive extension and main memory.
- CPU side programs source/destination addresses, word count and direction, then pulses start.
- Drives the drive's we/oe/addr lines and the shared 16-bit tristate drive bus. Sits between the CPU's I/O decode and the drive extension.

Parameters:
- DRIVE_AW, 24, drive word-address width
- MEM_AW, 16, memory word-address width
- DW, 16, data word width
- CNT_W, 16, transfer word-count width

Ports:
- clk  input  1  system clock
- r  input  1  reset, synchronous, active-low
- start  input  1  command strobe, sampled in IDLE only
- dir  input  1  0 = drive->memory, 1 = memory->drive
- cmd_drive_addr  input  DRIVE_AW  first drive word address
- cmd_mem_addr  input  MEM_AW  first memory word address
- cmd_count  input  CNT_W  words to transfer
- busy  output  1  high in every non-IDLE state
- done  output  1  one-cycle completion pulse
- checksum  output  DW  running word sum (see Optional Feature)
- drive_bus  inout  DW  shared drive data bus
- drive_addr  output  DRIVE_AW  drive word address
- drive_we  output  1  drive write strobe, captured by drive at posedge
- drive_oe  output  1  drive output enable, read data valid combinationally
- mem_addr  output  MEM_AW  memory word address
- mem_wdata  output  DW  memory write data
- mem_rdata  input  DW  memory read data, valid combinationally while mem_oe
- mem_we  output  1  memory write strobe
- mem_oe  output  1  memory output enable

Behaviour:
- Reset (r=0 at posedge):
  - State IDLE.
  - busy, done, drive_we, drive_oe, mem_we and mem_oe are 0.
  - drive_addr, mem_addr, mem_wdata, checksum and the holding register are 0.
  - drive_bus is released (z).
  - Reset mid-transfer aborts immediately; a partial transfer is not resumed and done is not pulsed.
- States: IDLE, FETCH, STORE, DONE.
- IDLE:
  - start=1 latches dir, both addresses and cmd_count.
  - Count 0 -> DONE. Otherwise -> FETCH.
- FETCH (one cycle):
  - Asserts the source oe (drive_oe if dir=0, mem_oe if dir=1) with the current source address.
  - Source data is captured into the holding register at the posedge ending the cycle.
  - -> STORE.
- STORE (one cycle):
  - Asserts the destination we with the holding register on the data path: drive_bus if dir=1, mem_wdata if dir=0.
  - At the posedge: both addresses increment, remaining count decrements.
  - Remaining count 1 -> DONE, else -> FETCH.
- DONE:
  - done=1 and busy=1 for exactly one cycle, then -> IDLE.
- Timing: latency is 2N cycles of bus activity plus one DONE cycle. done is asserted 2N+1 cycles after the start edge, or 1 cycle after it for N=0.
- Address wrap: drive_addr wraps modulo 2^DRIVE_AW; mem_addr wraps modulo 2^MEM_AW. No error is flagged.
- Bus ownership:
  - drive_bus is driven only while drive_we=1; otherwise it is z.
  - drive_we and drive_oe are never high in the same cycle.
  - mem_we and mem_oe are never high in the same cycle.
- All strobes are 0 in IDLE and DONE.
- start while busy is ignored; no queueing.
- cmd_* inputs are don't-care except in the IDLE start cycle.

Optional Feature:
- Macro: DRIVE_DMA_CHECKSUM_EN.
- With the macro:
  - checksum clears to 0 when a command is accepted.
  - In each STORE cycle, checksum adds the transferred word modulo 2^DW.
  - The value is stable from DONE until the next accepted start.
- Without the macro: checksum is tied to 0 and no adder is built.

Test Plan:
- Drive->memory: drive[0x000010..0x000013] = 0x1111, 0x2222, 0x3333, 0x4444; start with dir=0, mem 0x0200, count 4.
  - Memory 0x0200..0x0203 holds those words.
  - done is asserted 9 cycles after the start edge.
  - checksum = 0xAAAA when the macro is defined.
- Memory->drive: mem[0xFFFE]=0xBEEF, mem[0xFFFF]=0xCAFE; dir=1, drive 0xFFFFFF, count 3.
  - mem_addr wraps to 0x0000.
  - drive[0xFFFFFF]=0xBEEF, drive[0x000000]=0xCAFE, drive[0x000001]=mem[0x0000].
- Count 0:
  - done is asserted the cycle after start; busy is high only that cycle.
  - No we/oe activity.
- Start while busy:
  - A second start during a 4-word transfer is ignored.
  - Exactly 4 writes occur and one done pulse.
- Reset mid-transfer:
  - r=0 during STORE of word 2 of 5.
  - Next cycle: all strobes 0, drive_bus z, busy 0, no done pulse.
  - A subsequent 1-word command completes normally.
- Bus checker, run throughout all tests:
  - drive_bus is never driven while drive_oe=1.
  - drive_we and drive_oe are never both high.
